// File: rtl/frame_mem_port.sv
`default_nettype none
// ============================================================================
// Module : frame_mem_port
// Maps format-controller requests onto a synchronous frame SRAM and returns
// read words in order at a fixed latency.
// Rev    : 1.0
// ============================================================================
module frame_mem_port #(
  parameter int                ADDR_W       = 16,
  parameter int                ROW_WORDS    = 128,
  parameter logic [ADDR_W-1:0] TEM_BASE     = 'h0000,
  parameter logic [ADDR_W-1:0] WIN_BASE     = 'h4000,
  parameter logic [ADDR_W-1:0] RES_BASE     = 'h8000,
  parameter int                TEM_ROWS     = 16,
  parameter int                TEM_COLS     = 4,
  parameter int                WIN_ROWS     = 48,
  parameter int                WIN_COLS     = 12,
  parameter int                READ_LATENCY = 2,
  parameter int                MAX_OUT      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rd_wr,
  input  logic              tem_win,
  input  logic [6:0]        row,
  input  logic [6:0]        col,
  input  logic [31:0]       write_data,
  input  logic              frame_clr,
  output logic              ack,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              read_tag,
  output logic              read_err,
  input  logic              mem_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int                  c_OUTS_W    = $clog2(MAX_OUT + 1);
  localparam logic [c_OUTS_W-1:0] c_max_out   = c_OUTS_W'(MAX_OUT);
  localparam logic [ADDR_W-1:0]   c_row_words = ADDR_W'(ROW_WORDS);

  logic [c_OUTS_W-1:0]   r_outs_cnt;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [READ_LATENCY:0] r_pv;
  logic [READ_LATENCY:0] r_pt;
  logic [READ_LATENCY:0] r_pe;
  logic [31:0]           r_read_data;
  logic                  r_read_valid;
  logic                  r_read_tag;
  logic                  r_read_err;
  logic [15:0]           r_rd_count;
  logic [15:0]           r_wr_count;

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_in_range;
  logic              w_issue;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_addr;

  always_comb begin
    w_offset = ADDR_W'(row) * c_row_words + ADDR_W'(col);
    if (rd_wr)
      w_addr = RES_BASE + w_offset;
    else if (tem_win)
      w_addr = WIN_BASE + w_offset;
    else
      w_addr = TEM_BASE + w_offset;

    if (tem_win)
      w_in_range = (32'(row) < WIN_ROWS) && (32'(col) < WIN_COLS);
    else
      w_in_range = (32'(row) < TEM_ROWS) && (32'(col) < TEM_COLS);

    // ack is held low while reset is applied so the port looks fully idle
    w_rd_acc = ~rst & req & ~rd_wr & mem_gnt & (r_outs_cnt < c_max_out);
    w_wr_acc = ~rst & req &  rd_wr & mem_gnt & (r_outs_cnt == '0);
    w_issue  = w_wr_acc | (w_rd_acc & w_in_range);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outs_cnt   <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_pv         <= '0;
      r_pt         <= '0;
      r_pe         <= '0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_read_tag   <= 1'b0;
      r_read_err   <= 1'b0;
      r_rd_count   <= '0;
      r_wr_count   <= '0;
    end else begin
      r_mem_en <= w_issue;
      r_mem_we <= w_wr_acc;
      if (w_issue)
        r_mem_addr <= w_addr;
      if (w_wr_acc)
        r_mem_wdata <= write_data;

      // out-of-range reads still occupy a slot so returns stay in order
      r_pv <= {r_pv[READ_LATENCY-1:0], w_rd_acc};
      r_pt <= {r_pt[READ_LATENCY-1:0], tem_win};
      r_pe <= {r_pe[READ_LATENCY-1:0], ~w_in_range};

      r_read_valid <= r_pv[READ_LATENCY];
      r_read_tag   <= r_pv[READ_LATENCY] & r_pt[READ_LATENCY];
      r_read_err   <= r_pv[READ_LATENCY] & r_pe[READ_LATENCY];
      r_read_data  <= (r_pv[READ_LATENCY] & ~r_pe[READ_LATENCY]) ? mem_rdata : '0;

      case ({w_rd_acc, r_read_valid})
        2'b10:   r_outs_cnt <= r_outs_cnt + 1'b1;
        2'b01:   r_outs_cnt <= r_outs_cnt - 1'b1;
        default: r_outs_cnt <= r_outs_cnt;
      endcase

      if (frame_clr)
        r_rd_count <= '0;
      else if (r_read_valid)
        r_rd_count <= r_rd_count + 16'd1;

      if (frame_clr)
        r_wr_count <= '0;
      else if (w_wr_acc)
        r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign ack        = w_rd_acc | w_wr_acc;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
  assign read_tag   = r_read_tag;
  assign read_err   = r_read_err;
  assign rd_count   = r_rd_count;
  assign wr_count   = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_frame_mem_port.sv
`default_nettype none
// ============================================================================
// Module : tb_frame_mem_port
// Directed vector table plus multi-cycle sequences for frame_mem_port.
// Rev    : 1.0
// ============================================================================
module tb_frame_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        rd_wr;
  logic        tem_win;
  logic [6:0]  row;
  logic [6:0]  col;
  logic [31:0] write_data;
  logic        frame_clr;
  logic        ack;
  logic [31:0] read_data;
  logic        read_valid;
  logic        read_tag;
  logic        read_err;
  logic        mem_gnt;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  frame_mem_port dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .rd_wr      (rd_wr),
    .tem_win    (tem_win),
    .row        (row),
    .col        (col),
    .write_data (write_data),
    .frame_clr  (frame_clr),
    .ack        (ack),
    .read_data  (read_data),
    .read_valid (read_valid),
    .read_tag   (read_tag),
    .read_err   (read_err),
    .mem_gnt    (mem_gnt),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rd_count   (rd_count),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return (a == 16'h0783) ? 32'hDEADBEEF : {a, ~a};
  endfunction

  // two-cycle synchronous SRAM; garbage when not enabled
  logic        r_en1;
  logic [15:0] r_a1;
  always @(posedge clk) begin
    r_en1     <= mem_en;
    r_a1      <= mem_addr;
    mem_rdata <= r_en1 ? mem_word(r_a1) : 32'hBADBAD00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    tick();
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
  endtask

  typedef struct {
    logic        rd_wr;
    logic        tem_win;
    logic [6:0]  row;
    logic [6:0]  col;
    logic [31:0] wdata;
    logic        exp_en;
    logic [15:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_tag;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v, input int idx);
    tick();
    req = 1'b1; rd_wr = v.rd_wr; tem_win = v.tem_win;
    row = v.row; col = v.col; write_data = v.wdata;
    #1;
    chk($sformatf("v%0d_ack", idx), ack, 1);
    tick();
    req = 1'b0;
    #1;
    chk($sformatf("v%0d_mem_en", idx), mem_en, v.exp_en);
    chk($sformatf("v%0d_mem_we", idx), mem_we, v.rd_wr);
    if (v.exp_en) chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_addr);
    if (v.rd_wr) begin
      chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_data);
    end else begin
      tick(); tick(); #1;
      chk($sformatf("v%0d_valid_early", idx), read_valid, 0);
      tick(); #1;
      chk($sformatf("v%0d_valid", idx), read_valid, 1);
      chk($sformatf("v%0d_data", idx), read_data, v.exp_data);
      chk($sformatf("v%0d_tag", idx), read_tag, v.exp_tag);
      chk($sformatf("v%0d_err", idx), read_err, v.exp_err);
    end
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] expq[$];
    logic [15:0] ack_bits;
    int nacc;
    int nret;
    int cyc;
    int bad;

    rst = 1'b1; req = 1'b0; rd_wr = 1'b0; tem_win = 1'b0; row = '0; col = '0;
    write_data = '0; frame_clr = 1'b0; mem_gnt = 1'b1;

    //         rd_wr tw  row  col  wdata          en  addr      data           tag err
    vecs[0] = '{1'b0, 1'b0, 7'd15,  7'd3,   32'h0,        1'b1, 16'h0783, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 7'd2,   7'd3,   32'h0,        1'b1, 16'h4103, 32'h4103BEFC, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 7'd16,  7'd0,   32'h0,        1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 7'd0,   7'd4,   32'h0,        1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 7'd47,  7'd11,  32'h0,        1'b1, 16'h578B, 32'h578BA874, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 7'd48,  7'd0,   32'h0,        1'b0, 16'h0000, 32'h00000000, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 7'd0,   7'd12,  32'h0,        1'b0, 16'h0000, 32'h00000000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 7'd1,   7'd1,   32'h12345678, 1'b1, 16'h8081, 32'h12345678, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 7'd127, 7'd127, 32'hCAFEF00D, 1'b1, 16'hBFFF, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 7'd0,   7'd0,   32'h0,        1'b1, 16'h0000, 32'h0000FFFF, 1'b0, 1'b0};

    tick(); tick(); #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_read_valid", read_valid, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    rst = 1'b0;
    tick(); tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
    #1;
    chk("tbl_rd_count", rd_count, 8);
    chk("tbl_wr_count", wr_count, 2);

    // six back-to-back reads against the in-flight limit
    pulse_clr();
    ack_bits = '0; nacc = 0; nret = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (nacc < 6) begin
        req = 1'b1; rd_wr = 1'b0; tem_win = 1'b0; row = 7'(nacc); col = '0;
      end else begin
        req = 1'b0;
      end
      #1;
      if (ack) begin
        ack_bits[c] = 1'b1;
        expq.push_back(mem_word(16'(nacc * 128)));
        nacc++;
      end
      if (read_valid) begin
        if (expq.size() == 0) chk("b2b_spurious_valid", 1, 0);
        else chk($sformatf("b2b_data%0d", nret), read_data, expq.pop_front());
        nret++;
      end
    end
    chk("b2b_ack_pattern", ack_bits, 16'h006F);
    chk("b2b_returns", nret, 6);
    chk("b2b_rd_count", rd_count, 6);

    // write waits for the outstanding read to drain
    pulse_clr();
    tick();
    req = 1'b1; rd_wr = 1'b0; tem_win = 1'b0; row = '0; col = '0;
    #1;
    chk("rw_rd_ack", ack, 1);
    tick();
    cyc = 1;
    rd_wr = 1'b1; row = 7'd1; col = 7'd1; write_data = 32'hA5A55A5A;
    #1;
    while (!ack && cyc < 20) begin
      tick(); cyc++; #1;
    end
    chk("rw_wr_ack_cycle", cyc, 5);
    tick();
    req = 1'b0;
    #1;
    chk("rw_mem_we", mem_we, 1);
    chk("rw_mem_en", mem_en, 1);
    chk("rw_mem_addr", mem_addr, 16'h8081);
    chk("rw_mem_wdata", mem_wdata, 32'hA5A55A5A);
    chk("rw_wr_count", wr_count, 1);

    // grant withheld for three cycles
    tick();
    mem_gnt = 1'b0; req = 1'b1; rd_wr = 1'b0; tem_win = 1'b0; row = 7'd3; col = 7'd1;
    #1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (ack || mem_en) bad++;
      if (k < 2) begin tick(); #1; end
    end
    chk("gnt_stall", bad, 0);
    tick();
    mem_gnt = 1'b1;
    #1;
    chk("gnt_ack", ack, 1);
    tick();
    req = 1'b0;
    #1;
    chk("gnt_mem_en", mem_en, 1);
    chk("gnt_mem_addr", mem_addr, 16'h0181);
    repeat (6) tick();

    // frame_clr in the same cycle as a return
    pulse_clr();
    tick();
    req = 1'b1; rd_wr = 1'b0; tem_win = 1'b0; row = 7'd0; col = 7'd0;
    tick();
    row = 7'd1;
    tick();
    req = 1'b0;
    tick();
    tick();
    frame_clr = 1'b1;
    #1;
    chk("clr_valid_a", read_valid, 1);
    tick();
    frame_clr = 1'b0;
    #1;
    chk("clr_rd_count_zero", rd_count, 0);
    chk("clr_valid_b", read_valid, 1);
    tick(); #1;
    chk("clr_rd_count_after", rd_count, 1);
    repeat (4) tick();

    // reset with three reads in flight
    for (int k = 0; k < 3; k++) begin
      tick();
      req = 1'b1; rd_wr = 1'b0; tem_win = 1'b0; row = 7'(k); col = '0;
    end
    tick();
    rst = 1'b1;
    #1;
    chk("arst_mem_en", mem_en, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_ack", ack, 0);
    chk("arst_read_valid", read_valid, 0);
    chk("arst_rd_count", rd_count, 0);
    req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick(); #1;
      if (read_valid) bad++;
    end
    chk("arst_no_stale_valid", bad, 0);
    tick();
    req = 1'b1; rd_wr = 1'b1; row = 7'd0; col = 7'd0;
    #1;
    chk("arst_wr_ack", ack, 1);
    tick();
    req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
